// File: rtl/icache_fill_ctrl_pkg.sv
// Shared constants for the instruction-cache miss fill controller.
// State encoding, address field slices, and tag-entry formatting.
package icache_fill_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int WORDS  = 8;
    localparam int SETS   = 64;

    localparam int TAG_MSB = 15;
    localparam int TAG_LSB = 10;
    localparam int IDX_MSB = 9;
    localparam int IDX_LSB = 4;
    localparam int OFF_MSB = 3;
    localparam int OFF_LSB = 1;

    localparam int TAG_VALID_BIT = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [WORDS-1:0] onehot_word(input logic [2:0] idx);
        return WORDS'(1) << idx;
    endfunction

    // Tag entry layout: valid bit on top, one spare zero bit, then the 6-bit tag.
    function automatic logic [7:0] make_tag_entry(input logic [TAG_MSB-TAG_LSB:0] tag);
        logic [7:0] entry;
        entry = {2'b00, tag};
        entry[TAG_VALID_BIT] = 1'b1;
        return entry;
    endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// Bus bundle between the fetch/miss logic, pipelined memory and cache arrays.
// master = the fill controller, slave = its environment.
interface icache_fill_ctrl_if;
    import icache_fill_ctrl_pkg::*;

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              victim_way;
    logic [15:0]       memory_data;
    logic              memory_data_valid;
    logic              memory_req;
    logic [ADDR_W-1:0] memory_address;
    logic              fsm_busy;
    logic              fill_done;
    logic              write_en_0;
    logic              write_en_1;
    logic              data_wen;
    logic              tag_wen;
    logic [15:0]       data_in;
    logic [7:0]        tag_in;
    logic [WORDS-1:0]  word;
    logic [SETS-1:0]   block_en;

    modport master (
        input  miss_detected, miss_address, victim_way, memory_data, memory_data_valid,
        output memory_req, memory_address, fsm_busy, fill_done, write_en_0, write_en_1,
               data_wen, tag_wen, data_in, tag_in, word, block_en
    );

    modport slave (
        output miss_detected, miss_address, victim_way, memory_data, memory_data_valid,
        input  memory_req, memory_address, fsm_busy, fill_done, write_en_0, write_en_1,
               data_wen, tag_wen, data_in, tag_in, word, block_en
    );

endinterface

// File: rtl/icache_fill_ctrl_fill_word_counter.sv
// 3-bit halfword counter with start-offset load; idx = (start + count) mod 8,
// plus a one-hot decode of idx. Used for both request issue and data receive.
module icache_fill_ctrl_fill_word_counter
    import icache_fill_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [2:0]       start,
    input  logic             clr,
    input  logic             en,
    output logic [2:0]       cnt,
    output logic [2:0]       idx,
    output logic [WORDS-1:0] onehot
);

    logic [2:0] base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= 3'd0;
            base <= 3'd0;
        end else if (load) begin
            cnt  <= 3'd0;
            base <= start;
        end else if (clr) begin
            cnt  <= 3'd0;
            base <= 3'd0;
        end else if (en) begin
            cnt  <= cnt + 3'd1;
        end
    end

    assign idx    = base + cnt;
    assign onehot = onehot_word(idx);

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss fill controller: 8 halfword reads, data writes, tag write.
// Build option ICACHE_FILL_CRITICAL_WORD_FIRST_EN starts the fill at the missed halfword.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    icache_fill_ctrl_if.master bus
);

    logic [1:0]        state;
    logic [11:0]       blk_addr;
    logic              way;
    logic              req_done;
    logic [2:0]        start_off;

    logic [2:0]        req_cnt;
    logic [2:0]        req_idx;
    logic [WORDS-1:0]  req_onehot_unused;
    logic [2:0]        rcv_cnt;
    logic [2:0]        rcv_idx_unused;
    logic [WORDS-1:0]  rcv_onehot;
    logic [3:0]        miss_off_unused;

    logic accept_miss;
    logic issue;
    logic outstanding;
    logic recv;
    logic last;

`ifdef ICACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_off = bus.miss_address[OFF_MSB:OFF_LSB];
`else
    assign start_off = 3'd0;
`endif
    assign miss_off_unused = bus.miss_address[3:0];

    assign accept_miss = (state == ST_IDLE) && bus.miss_detected;
    assign issue       = (state == ST_FILL) && !req_done;
    // Once all 8 requests are out every remaining return is legal; before that,
    // equal counters mean nothing is in flight and a valid is spurious.
    assign outstanding = req_done || (rcv_cnt != req_cnt);
    assign recv        = (state == ST_FILL) && bus.memory_data_valid && outstanding;
    assign last        = recv && (rcv_cnt == 3'd7);

    icache_fill_ctrl_fill_word_counter u_req_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (accept_miss),
        .start  (start_off),
        .clr    (state == ST_DONE),
        .en     (issue),
        .cnt    (req_cnt),
        .idx    (req_idx),
        .onehot (req_onehot_unused)
    );

    icache_fill_ctrl_fill_word_counter u_rcv_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (accept_miss),
        .start  (start_off),
        .clr    (state == ST_DONE),
        .en     (recv),
        .cnt    (rcv_cnt),
        .idx    (rcv_idx_unused),
        .onehot (rcv_onehot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            req_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_done <= 1'b0;
                    if (bus.miss_detected) state <= ST_FILL;
                end
                ST_FILL: begin
                    if (issue && (req_cnt == 3'd7)) req_done <= 1'b1;
                    if (last) state <= ST_DONE;
                end
                ST_DONE: begin
                    req_done <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    req_done <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Block address and way are only meaningful while filling; no reset needed.
    always_ff @(posedge clk) begin
        if (accept_miss) begin
            blk_addr <= bus.miss_address[TAG_MSB:IDX_LSB];
            way      <= bus.victim_way;
        end
    end

    assign bus.memory_req     = issue;
    assign bus.memory_address = issue ? {blk_addr, req_idx, 1'b0} : '0;
    assign bus.fsm_busy       = (state == ST_FILL);
    assign bus.fill_done      = (state == ST_DONE);
    assign bus.data_wen       = recv;
    assign bus.tag_wen        = last;
    assign bus.write_en_0     = recv && !way;
    assign bus.write_en_1     = recv && way;
    assign bus.data_in        = recv ? bus.memory_data : '0;
    assign bus.word           = recv ? rcv_onehot : '0;
    assign bus.tag_in         = last ? make_tag_entry(blk_addr[11:6]) : '0;
    assign bus.block_en       = recv ? (SETS'(1) << blk_addr[5:0]) : '0;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl with a latency-L pipelined memory model.
module tb_icache_fill_ctrl;
    import icache_fill_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_fill_ctrl_if bus();

    icache_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [7:0]  word;
        logic [15:0] data;
        logic        way;
        logic [63:0] blk;
    } wr_t;

    typedef struct {
        int          rdy;
        logic [15:0] d;
    } mem_t;

    wr_t         exp_wr_q[$];
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_tag_q[$];
    mem_t        mem_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 4;
    bit gaps = 1'b0;
    bit stray = 1'b0;
    int wr_cnt, tag_cyc, done_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic outputs_zero(input string tag);
        check({tag, "_ctrl"}, {bus.memory_req, bus.fsm_busy, bus.fill_done, bus.write_en_0,
                               bus.write_en_1, bus.data_wen, bus.tag_wen}, 0);
        check({tag, "_addr"}, bus.memory_address, 0);
        check({tag, "_data"}, {bus.data_in, bus.tag_in, bus.word}, 0);
        check({tag, "_blk"}, bus.block_en, 0);
    endtask

    task automatic expect_fill(input logic [15:0] a, input logic w);
        logic [2:0]  start;
        logic [2:0]  idx;
        logic [15:0] ra;
        wr_t         e;
        start = 3'd0;
`ifdef ICACHE_FILL_CRITICAL_WORD_FIRST_EN
        start = a[3:1];
`endif
        for (int n = 0; n < 8; n++) begin
            idx = start + 3'(n);
            ra  = {a[15:4], idx, 1'b0};
            exp_addr_q.push_back(ra);
            e.word = 8'b1 << idx;
            e.data = mem_word(ra);
            e.way  = w;
            e.blk  = 64'b1 << a[9:4];
            exp_wr_q.push_back(e);
        end
        exp_tag_q.push_back({2'b10, a[15:10]});
    endtask

    // Entered and left at a falling edge: drive, settle, sample, then cross the rising edge.
    task automatic step();
        wr_t  e;
        mem_t m;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'($urandom);
        if (stray) begin
            bus.memory_data_valid = 1'b1;
        end else if (mem_q.size() > 0 && mem_q[0].rdy <= cyc && (!gaps || (cyc % 3) == 0)) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = mem_q[0].d;
            void'(mem_q.pop_front());
        end
        #1;
        if (exp_addr_q.size() == 0) check("no_req", bus.memory_req, 0);
        else if (bus.memory_req) check("req_addr", bus.memory_address, exp_addr_q.pop_front());
        if (bus.memory_req) begin
            m.rdy = cyc + lat;
            m.d   = mem_word(bus.memory_address);
            mem_q.push_back(m);
        end
        if (exp_wr_q.size() == 0) begin
            check("no_wen", bus.data_wen, 0);
            check("no_tag", bus.tag_wen, 0);
        end else if (bus.data_wen) begin
            e = exp_wr_q.pop_front();
            wr_cnt++;
            check("word", bus.word, e.word);
            check("data_in", bus.data_in, e.data);
            check("we0", bus.write_en_0, !e.way);
            check("we1", bus.write_en_1, e.way);
            check("block_en", bus.block_en, e.blk);
            check("tag_wen", bus.tag_wen, exp_wr_q.size() == 0);
            if (bus.tag_wen && exp_tag_q.size() > 0) begin
                check("tag_in", bus.tag_in, exp_tag_q.pop_front());
                tag_cyc = cyc;
            end
        end else begin
            check("tag_no_data", bus.tag_wen, 0);
        end
        if (bus.fill_done) begin
            done_cyc = cyc;
            check("busy_in_done", bus.fsm_busy, 0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        outputs_zero("rst_mid");
        exp_wr_q.delete();
        exp_addr_q.delete();
        exp_tag_q.delete();
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("post_rst_busy", bus.fsm_busy, 0);
            step();
        end
    endtask

    task automatic run_fill(input logic [15:0] a, input logic w, input int l, input bit g,
                            input int inject_at, input int reset_after);
        int miss_cyc;
        lat = l;
        gaps = g;
        wr_cnt = 0;
        tag_cyc = -1;
        done_cyc = -1;
        expect_fill(a, w);
        bus.miss_detected = 1'b1;
        bus.miss_address  = a;
        bus.victim_way    = w;
        miss_cyc = cyc;
        step();
        bus.miss_detected = 1'b0;
        bus.miss_address  = 16'($urandom);
        bus.victim_way    = !w;
        check("busy_rise", bus.fsm_busy, 1);
        for (int i = 0; i < 80 && done_cyc < 0; i++) begin
            if (i == inject_at) begin
                bus.miss_detected = 1'b1;
                bus.miss_address  = 16'h4000;
            end else begin
                bus.miss_detected = 1'b0;
            end
            if (reset_after > 0 && wr_cnt == reset_after) begin
                do_reset();
                return;
            end
            step();
        end
        bus.miss_detected = 1'b0;
        check("fill_done_seen", done_cyc >= 0, 1);
        check("done_after_tag", done_cyc, tag_cyc + 1);
        check("writes", wr_cnt, 8);
        check("addr_q_empty", exp_addr_q.size(), 0);
        check("idle_busy", bus.fsm_busy, 0);
        if (!g) check("latency", done_cyc - miss_cyc, 9 + l);
    endtask

    initial begin
        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0;
        bus.victim_way        = 1'b0;
        bus.memory_data       = 16'h0;
        bus.memory_data_valid = 1'b0;
        @(negedge clk);
        #1;
        outputs_zero("rst0");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_fill(16'h1234, 1'b0, 4, 1'b0, -1, 0);
        run_fill(16'hFC02, 1'b1, 3, 1'b1, -1, 0);
        run_fill(16'h2000, 1'b0, 2, 1'b0, 3, 0);

        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stray_busy", bus.fsm_busy, 0);
            step();
        end
        stray = 1'b0;
        check("stray_busy_after", bus.fsm_busy, 0);

        run_fill(16'h1234, 1'b0, 4, 1'b0, -1, 3);
        run_fill(16'h0100, 1'b1, 1, 1'b0, -1, 0);
`ifdef ICACHE_FILL_CRITICAL_WORD_FIRST_EN
        run_fill(16'h123A, 1'b0, 5, 1'b0, -1, 0);
`endif
        run_fill(16'hABCE, 1'b1, 6, 1'b0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
